riscv_uart_tx: RTL

RISCV_UART_TX -- requirements
Module: riscv_uart_tx

---
 rtl/riscv_uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 41 ++++
 rtl/riscv_uart_tx.sv | 101 ++++++++++
 3 files changed

// File: rtl/riscv_uart_pkg.sv
// riscv_uart_pkg: register map, STATUS layout and transmitter state encoding
package riscv_uart_pkg;
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_e;
  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY] = busy;
    s[ST_OVF] = ovf;
    s[ST_CNT_LSB +: 4] = cnt;
    return s;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken when a pop happens the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register
module riscv_uart_tx
  import riscv_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  tx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shreg_q, head;
  logic tx_q, ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic full, empty, push, pop, sel_tx, sel_st;
  logic [AW:0] count;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  assign sel_tx = addr == BASE_ADDR + TXDATA_OFF;
  assign sel_st = addr == BASE_ADDR + STATUS_OFF;
  assign push   = wr_en && sel_tx;
  assign pop    = state_q == IDLE && !empty;
  assign status = status_word(full, empty, state_q != IDLE, ovf_q, 4'(count));
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (wdata[7:0]),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  // a drop in the same cycle as a STATUS read stays visible to the next read
  always_comb begin
    ovf_d   = (push && full && !pop) || (ovf_q && !(rd_en && sel_st));
    rdata_d = rd_en ? (sel_st ? status : '0) : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          cnt_q   <= DIV_M1;
          shreg_q <= head;
          tx_q    <= 1'b0;
        end
        START: if (cnt_q == '0) begin
          state_q <= DATA;
          cnt_q   <= DIV_M1;
          idx_q   <= '0;
          tx_q    <= shreg_q[0];
        end else cnt_q <= cnt_q - CW'(1);
        DATA: if (cnt_q == '0) begin
          cnt_q <= DIV_M1;
          if (idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            idx_q   <= idx_q + 3'd1;
            shreg_q <= shreg_q >> 1;
            tx_q    <= shreg_q[1];
          end
        end else cnt_q <= cnt_q - CW'(1);
        STOP: if (cnt_q == '0) state_q <= IDLE;
              else cnt_q <= cnt_q - CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rdata = rdata_q;
  assign tx    = tx_q;
endmodule
